seg7_bcd_capture: RTL and testbench

SEG7_BCD_CAPTURE -- requirements
Module: seg7_bcd_capture

---
 rtl/seg7_bcd_capture.sv | 167 ++++++++++++++++
 tb/tb_seg7_bcd_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_capture.sv
// Seven-segment capture: debounces an active-low segment bus and decodes it to BCD.
// Optional SEG7_ERRCNT_EN adds a saturating err_cnt port counting invalid captures.
module seg7_bcd_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] bcd_out,
  output logic       bcd_valid,
  input  logic       bcd_ready,
  output logic       ovf,
  output logic       invalid
`ifdef SEG7_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [3:0] STB = 4'(STABLE_CYCLES);

  typedef enum logic {
    TRACK   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] prev_q, prev_d;
  logic [6:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
  logic [3:0] bcd_q, bcd_d;
  logic       ovf_q, ovf_d;
  logic       inv_q, inv_d;
  logic [3:0] dec_bcd;
  logic       dec_ovf;
  logic       dec_inv;
  logic       capture;

`ifdef SEG7_ERRCNT_EN
  logic [7:0] err_q, err_d;
`endif

  // Pattern decode of the live segment bus (bit6=g .. bit0=a)
  always_comb begin
    dec_bcd = 4'hE;
    dec_ovf = 1'b0;
    dec_inv = 1'b1;
    case (seg_in)
      7'b1000000: begin dec_bcd = 4'd0; dec_inv = 1'b0; end
      7'b1111001: begin dec_bcd = 4'd1; dec_inv = 1'b0; end
      7'b0100100: begin dec_bcd = 4'd2; dec_inv = 1'b0; end
      7'b0110000: begin dec_bcd = 4'd3; dec_inv = 1'b0; end
      7'b0011001: begin dec_bcd = 4'd4; dec_inv = 1'b0; end
      7'b0010010: begin dec_bcd = 4'd5; dec_inv = 1'b0; end
      7'b0000010: begin dec_bcd = 4'd6; dec_inv = 1'b0; end
      7'b1111000: begin dec_bcd = 4'd7; dec_inv = 1'b0; end
      7'b0000000: begin dec_bcd = 4'd8; dec_inv = 1'b0; end
      7'b0011000: begin dec_bcd = 4'd9; dec_inv = 1'b0; end
      7'b0111111: begin
        dec_bcd = 4'hF;
        dec_ovf = 1'b1;
        dec_inv = 1'b0;
      end
      default: begin
        dec_bcd = 4'hE;
        dec_ovf = 1'b0;
        dec_inv = 1'b1;
      end
    endcase
  end

  // Next-state: stability tracking, capture, and handshake release
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    inv_d      = inv_q;
    capture    = 1'b0;
`ifdef SEG7_ERRCNT_EN
    err_d      = err_q;
`endif
    unique case (state_q)
      TRACK: begin
        prev_d = seg_in;
        if (seg_in != prev_q) begin
          cnt_d = 4'd1;
        end else if (cnt_q < STB) begin
          cnt_d = cnt_q + 4'd1;
        end
        // A change on this edge forces cnt_d=1, so no capture then
        capture = (cnt_d == STB) &&
                  (!last_vld_q || (seg_in != last_q));
        if (capture) begin
          bcd_d      = dec_bcd;
          ovf_d      = dec_ovf;
          inv_d      = dec_inv;
          last_d     = seg_in;
          last_vld_d = 1'b1;
          cnt_d      = 4'd0;
          state_d    = PRESENT;
`ifdef SEG7_ERRCNT_EN
          if (dec_inv && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
`endif
        end
      end
      PRESENT: begin
        cnt_d = 4'd0;
        if (bcd_ready) begin
          state_d = TRACK;
        end
      end
      default: begin
        state_d = TRACK;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TRACK;
      cnt_q      <= 4'd0;
      prev_q     <= 7'h7F;
      last_q     <= 7'h00;
      last_vld_q <= 1'b0;
      bcd_q      <= 4'd0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      inv_q      <= inv_d;
    end
  end

`ifdef SEG7_ERRCNT_EN
  // Invalid-capture counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 8'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

  assign bcd_valid = (state_q == PRESENT);
  assign bcd_out   = bcd_q;
  assign ovf       = ovf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Self-checking bench for seg7_bcd_capture: decode table plus handshake corners.
// Define SEG7_ERRCNT_EN to also check the err_cnt port.
module tb_seg7_bcd_capture;

  localparam int S = 4;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] bcd;
    logic       ovf;
    logic       inv;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       bcd_ready = 1'b0;
  logic [3:0] bcd_out;
  logic       bcd_valid;
  logic       ovf;
  logic       invalid;
`ifdef SEG7_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_err = 0;
  vec_t sb[$];
  vec_t tbl[14];

  seg7_bcd_capture #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .ovf       (ovf),
    .invalid   (invalid)
`ifdef SEG7_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] b, input logic o, input logic v);
    vec_t e;
    e.seg = seg_in;
    e.bcd = b;
    e.ovf = o;
    e.inv = v;
    sb.push_back(e);
  endtask

  // Scoreboard: every transfer must match the oldest expected result
  always @(negedge clk) begin
    vec_t e;
    if (!rst && bcd_valid && bcd_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_xfer: got bcd=%0h expected none", bcd_out);
      end else begin
        e = sb.pop_front();
        check("xfer_bcd", int'(bcd_out), int'(e.bcd));
        check("xfer_ovf", int'(ovf), int'(e.ovf));
        check("xfer_inv", int'(invalid), int'(e.inv));
      end
    end
  end

  initial begin
    int nv;
    tbl[0]  = '{7'b1000000, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{7'b1111001, 4'h1, 1'b0, 1'b0};
    tbl[2]  = '{7'b0100100, 4'h2, 1'b0, 1'b0};
    tbl[3]  = '{7'b0110000, 4'h3, 1'b0, 1'b0};
    tbl[4]  = '{7'b0011001, 4'h4, 1'b0, 1'b0};
    tbl[5]  = '{7'b0010010, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{7'b0000010, 4'h6, 1'b0, 1'b0};
    tbl[7]  = '{7'b1111000, 4'h7, 1'b0, 1'b0};
    tbl[8]  = '{7'b0000000, 4'h8, 1'b0, 1'b0};
    tbl[9]  = '{7'b0011000, 4'h9, 1'b0, 1'b0};
    tbl[10] = '{7'b0111111, 4'hF, 1'b1, 1'b0};
    tbl[11] = '{7'b1010101, 4'hE, 1'b0, 1'b1};
    tbl[12] = '{7'b0000001, 4'hE, 1'b0, 1'b1};
    tbl[13] = '{7'b1111111, 4'hE, 1'b0, 1'b1};

    // Reset state
    step(3);
    check("rst_valid", int'(bcd_valid), 0);
    check("rst_bcd", int'(bcd_out), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_inv", int'(invalid), 0);
`ifdef SEG7_ERRCNT_EN
    check("rst_err", int'(err_cnt), 0);
`endif

    // Exact latency: first edge with the pattern is edge k
    rst = 1'b0;
    seg_in = 7'b0100100;
    bcd_ready = 1'b1;
    step(S - 1);
    check("lat_early", int'(bcd_valid), 0);
    push(4'h2, 1'b0, 1'b0);
    step(1);
    check("lat_valid", int'(bcd_valid), 1);
    check("lat_bcd", int'(bcd_out), 2);
    step(1);
    check("pulse_end", int'(bcd_valid), 0);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bcd_valid) nv++;
    end
    check("no_dup_2", nv, 0);

    // Decode table with ready held high
    for (int i = 0; i < 14; i++) begin
      seg_in = tbl[i].seg;
      push(tbl[i].bcd, tbl[i].ovf, tbl[i].inv);
      if (tbl[i].inv) exp_err++;
      step(S + 1);
      check("tbl_drained", sb.size(), 0);
`ifdef SEG7_ERRCNT_EN
      check("tbl_err", int'(err_cnt), exp_err);
`endif
    end

    // Backpressure: result held while ready low, input ignored
    bcd_ready = 1'b0;
    seg_in = 7'b0011000;
    push(4'h9, 1'b0, 1'b0);
    step(10);
    check("bp_valid", int'(bcd_valid), 1);
    check("bp_bcd", int'(bcd_out), 9);
    seg_in = 7'b1111001;
    step(3);
    check("bp_hold_valid", int'(bcd_valid), 1);
    check("bp_hold_bcd", int'(bcd_out), 9);
    bcd_ready = 1'b1;
    push(4'h1, 1'b0, 1'b0);
    step(1);
    check("bp_release", int'(bcd_valid), 0);
    step(S + 1);
    check("bp_drained", sb.size(), 0);

    // Toggling every 2 cycles never stabilises
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      seg_in = (i % 2 == 1) ? 7'b1111001 : 7'b1111000;
      step(1);
      if (bcd_valid) nv++;
      step(1);
      if (bcd_valid) nv++;
    end
    check("toggle_none", nv, 0);

    // Change on the edge the count would complete
    seg_in = 7'b0110000;
    step(S - 1);
    check("edge_a", int'(bcd_valid), 0);
    seg_in = 7'b0011001;
    step(S - 1);
    check("edge_b", int'(bcd_valid), 0);
    push(4'h4, 1'b0, 1'b0);
    step(1);
    check("edge_cap", int'(bcd_valid), 1);
    step(1);
    check("edge_drained", sb.size(), 0);

    // Held 8 yields exactly one capture
    seg_in = 7'b0000000;
    push(4'h8, 1'b0, 1'b0);
    step(S);
    check("hold8_valid", int'(bcd_valid), 1);
    step(1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bcd_valid) nv++;
    end
    check("hold8_once", nv, 0);

    // Reset while presenting discards the result
    bcd_ready = 1'b0;
    seg_in = 7'b0010010;
    step(S);
    check("rp_valid", int'(bcd_valid), 1);
    check("rp_bcd", int'(bcd_out), 5);
    rst = 1'b1;
    step(1);
    check("rp_drop", int'(bcd_valid), 0);
    check("rp_bcd0", int'(bcd_out), 0);
    exp_err = 0;
`ifdef SEG7_ERRCNT_EN
    check("rp_err", int'(err_cnt), exp_err);
`endif
    rst = 1'b0;
    bcd_ready = 1'b1;
    push(4'h5, 1'b0, 1'b0);
    step(S - 1);
    check("rp_early", int'(bcd_valid), 0);
    step(1);
    check("rp_recap", int'(bcd_valid), 1);
    step(1);

    // First pattern after reset may be the blank 7F
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    seg_in = 7'h7F;
    push(4'hE, 1'b0, 1'b1);
    exp_err++;
    step(S - 1);
    check("blank_early", int'(bcd_valid), 0);
    step(1);
    check("blank_cap", int'(bcd_valid), 1);
    check("blank_inv", int'(invalid), 1);
    step(1);
`ifdef SEG7_ERRCNT_EN
    check("blank_err", int'(err_cnt), exp_err);
`endif

    step(2);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
